// File: rtl/izero_pkg.sv
// Shared definitions for the iZero instruction-memory slice.
package izero_pkg;

  // Loader FSM: clear memory, serve fetches, accept program words.
  typedef enum logic [1:0] {
    LIMPA    = 2'd0,
    EXECUCAO = 2'd1,
    CARGA    = 2'd2
  } estado_t;

  localparam int DATA_WIDTH_PADRAO = 32;
  localparam int PC_WIDTH_PADRAO   = 26;

  // All-zero word doubles as the core's NOP.
  localparam logic [DATA_WIDTH_PADRAO-1:0] NOP_WORD_PADRAO = '0;

endpackage

// File: rtl/memoria_sincrona_1w1r.sv
// Single-write, registered-read RAM; no reset so it maps onto block RAM.
module memoria_sincrona_1w1r #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 32,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

  // Write port plus registered read; caller guarantees no overlap of use.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/memoria_de_instrucoes_carregavel.sv
// Instruction memory with self-clear after reset and a valid/ready loader port.
module memoria_de_instrucoes_carregavel
  import izero_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_PADRAO,
  parameter int PC_WIDTH   = PC_WIDTH_PADRAO,
  parameter int MEM_SIZE   = 32,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] instrucao,
  output logic                  instrucao_valida,
  output logic                  pc_invalido,
  input  logic                  carga_inicio,
  input  logic [ADDR_WIDTH-1:0] carga_base,
  input  logic [DATA_WIDTH-1:0] carga_dado,
  input  logic                  carga_valida,
  input  logic                  carga_fim,
  output logic                  carga_pronta,
  output logic                  carregando,
  output logic [ADDR_WIDTH:0]   palavras_carregadas,
  output logic                  carga_estouro
);

  localparam logic [ADDR_WIDTH:0]   PTR_FIM    = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0]   PTR_ULTIMO = (ADDR_WIDTH+1)'(MEM_SIZE-1);
  localparam logic [ADDR_WIDTH:0]   UM         = (ADDR_WIDTH+1)'(1);
  localparam logic [PC_WIDTH-1:0]   PC_LIMITE  = PC_WIDTH'(MEM_SIZE);

  estado_t               r_estado, w_prox;
  logic [ADDR_WIDTH:0]   r_ponteiro;   // one extra bit so it can sit at MEM_SIZE
  logic [ADDR_WIDTH:0]   r_palavras;
  logic                  r_estouro;
  logic                  r_valida;
  logic                  r_pc_inv;

  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_cheio;
  logic                  w_aceita;

  assign w_cheio  = (r_ponteiro == PTR_FIM);
  assign w_aceita = (r_estado == CARGA) && carga_valida && !carga_inicio;

  // Next state and RAM write control.
  always_comb begin
    w_prox  = r_estado;
    w_we    = 1'b0;
    w_wdata = NOP_WORD;
    case (r_estado)
      LIMPA: begin
        w_we = 1'b1;
        if (r_ponteiro == PTR_ULTIMO) w_prox = EXECUCAO;
      end
      EXECUCAO: begin
        if (carga_inicio) w_prox = CARGA;
      end
      CARGA: begin
        if (!carga_inicio) begin
          if (w_aceita && !w_cheio) begin
            w_we    = 1'b1;
            w_wdata = carga_dado;
          end
          if (carga_fim) w_prox = EXECUCAO;
        end
      end
      default: w_prox = LIMPA;
    endcase
  end

  // State, pointer and load bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= LIMPA;
      r_ponteiro <= '0;
      r_palavras <= '0;
      r_estouro  <= 1'b0;
    end else begin
      r_estado <= w_prox;
      case (r_estado)
        LIMPA: begin
          r_ponteiro <= (r_ponteiro == PTR_ULTIMO) ? '0 : r_ponteiro + UM;
        end
        EXECUCAO, CARGA: begin
          if (carga_inicio) begin
            r_ponteiro <= {1'b0, carga_base};
            r_palavras <= '0;
            r_estouro  <= 1'b0;
          end else if (w_aceita) begin
            if (w_cheio) begin
              r_estouro <= 1'b1;            // word dropped, pointer stays saturated
            end else begin
              r_ponteiro <= r_ponteiro + UM;
              r_palavras <= r_palavras + UM;
            end
          end
        end
        default: r_ponteiro <= '0;
      endcase
    end
  end

  // Fetch qualifiers, aligned with the RAM's registered read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valida <= 1'b0;
      r_pc_inv <= 1'b0;
    end else begin
      r_valida <= (r_estado == EXECUCAO) && !carga_inicio;
      r_pc_inv <= (r_estado == EXECUCAO) && !carga_inicio && (pc >= PC_LIMITE);
    end
  end

  memoria_sincrona_1w1r #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_waddr (r_ponteiro[ADDR_WIDTH-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (pc[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  // Out-of-range fetches and non-fetch cycles present NOP.
  assign instrucao           = (r_valida && !r_pc_inv) ? w_rdata : NOP_WORD;
  assign instrucao_valida    = r_valida;
  assign pc_invalido         = r_pc_inv;
  assign carregando          = (r_estado == CARGA);
  assign carga_pronta        = (r_estado == CARGA);
  assign palavras_carregadas = r_palavras;
  assign carga_estouro       = r_estouro;

endmodule

// File: tb/tb_memoria_de_instrucoes_carregavel.sv
module tb_memoria_de_instrucoes_carregavel;

  localparam int DW = 32;
  localparam int PW = 26;
  localparam int MS = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] pc = '0;
  logic [DW-1:0] instrucao;
  logic          instrucao_valida, pc_invalido;
  logic          carga_inicio = 1'b0;
  logic [AW-1:0] carga_base = '0;
  logic [DW-1:0] carga_dado = '0;
  logic          carga_valida = 1'b0, carga_fim = 1'b0;
  logic          carga_pronta, carregando, carga_estouro;
  logic [AW:0]   palavras_carregadas;

  memoria_de_instrucoes_carregavel #(
    .DATA_WIDTH(DW), .PC_WIDTH(PW), .MEM_SIZE(MS)
  ) dut (
    .clock(clock), .reset(reset), .pc(pc),
    .instrucao(instrucao), .instrucao_valida(instrucao_valida), .pc_invalido(pc_invalido),
    .carga_inicio(carga_inicio), .carga_base(carga_base), .carga_dado(carga_dado),
    .carga_valida(carga_valida), .carga_fim(carga_fim), .carga_pronta(carga_pronta),
    .carregando(carregando), .palavras_carregadas(palavras_carregadas),
    .carga_estouro(carga_estouro)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nome, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 clearing, 1 running, 2 loading
  int          m_mode = 0;
  int          m_clear = 0;
  int          m_ptr = 0;
  int          m_loaded = 0;
  bit          m_ovf = 0;
  logic [31:0] m_mem [MS];
  logic [31:0] e_instr = '0;
  bit          e_valid = 0, e_inv = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_clear = 0; m_ptr = 0; m_loaded = 0; m_ovf = 0;
      e_instr = '0; e_valid = 0; e_inv = 0;
    end else begin
      e_instr = '0; e_valid = 0; e_inv = 0;
      case (m_mode)
        0: begin
          m_mem[m_clear] = '0;
          m_clear++;
          if (m_clear == MS) m_mode = 1;
        end
        1: begin
          if (carga_inicio) begin
            m_mode = 2; m_ptr = int'(carga_base); m_loaded = 0; m_ovf = 0;
          end else begin
            e_valid = 1;
            if (pc >= MS) e_inv = 1;
            else e_instr = m_mem[int'(pc)];
          end
        end
        default: begin
          if (carga_inicio) begin
            m_ptr = int'(carga_base); m_loaded = 0; m_ovf = 0;
          end else begin
            if (carga_valida) begin
              if (m_ptr < MS) begin
                m_mem[m_ptr] = carga_dado; m_ptr++; m_loaded++;
              end else m_ovf = 1;
            end
            if (carga_fim) m_mode = 1;
          end
        end
      endcase
    end
  end

  bit cmp_en = 0;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("instrucao", 64'(instrucao), 64'(e_instr));
      check("instrucao_valida", 64'(instrucao_valida), 64'(e_valid));
      check("pc_invalido", 64'(pc_invalido), 64'(e_inv));
      check("carregando", 64'(carregando), 64'(m_mode == 2));
      check("carga_pronta", 64'(carga_pronta), 64'(m_mode == 2));
      check("palavras_carregadas", 64'(palavras_carregadas), 64'(m_loaded));
      check("carga_estouro", 64'(carga_estouro), 64'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic prox();
    @(negedge clock);
    #1;
  endtask

  task automatic fetch(input logic [PW-1:0] a, input logic [31:0] exp, input bit inv, input string nome);
    pc = a;
    prox();
    check(nome, 64'(instrucao), 64'(exp));
    check({nome, "_inv"}, 64'(pc_invalido), 64'(inv));
    check({nome, "_vld"}, 64'(instrucao_valida), 64'd1);
  endtask

  task automatic palavra(input logic [31:0] d, input bit fim);
    carga_valida = 1'b1; carga_dado = d; carga_fim = fim;
    prox();
    carga_valida = 1'b0; carga_fim = 1'b0;
  endtask

  task automatic inicia(input logic [AW-1:0] base);
    carga_inicio = 1'b1; carga_base = base;
    prox();
    carga_inicio = 1'b0;
  endtask

  task automatic check_reset_vals(input string nome);
    check({nome, "_instr"}, 64'(instrucao), 64'd0);
    check({nome, "_vld"}, 64'(instrucao_valida), 64'd0);
    check({nome, "_inv"}, 64'(pc_invalido), 64'd0);
    check({nome, "_pronta"}, 64'(carga_pronta), 64'd0);
    check({nome, "_carr"}, 64'(carregando), 64'd0);
    check({nome, "_pal"}, 64'(palavras_carregadas), 64'd0);
    check({nome, "_est"}, 64'(carga_estouro), 64'd0);
  endtask

  initial begin
    cmp_en = 1;
    prox(); prox();
    check_reset_vals("reset");
    reset = 1'b1;

    // Clearing phase: 8 cycles with no load mode and no valid fetch.
    for (int i = 0; i < MS; i++) begin
      prox();
      check("limpa_carr", 64'(carregando), 64'd0);
      check("limpa_vld", 64'(instrucao_valida), 64'd0);
    end
    fetch(26'd3, 32'h0, 1'b0, "pos_limpa_pc3");

    // Basic load at base 0, end marker on the last word.
    inicia(3'd0);
    check("carga_pronta_on", 64'(carga_pronta), 64'd1);
    palavra(32'h78000004, 1'b0);
    palavra(32'h50010005, 1'b0);
    palavra(32'hFC000000, 1'b1);
    check("pal_3", 64'(palavras_carregadas), 64'd3);
    check("fim_carr", 64'(carregando), 64'd0);
    fetch(26'd1, 32'h50010005, 1'b0, "pc1");
    fetch(26'd3, 32'h0, 1'b0, "pc3");
    fetch(26'd0, 32'h78000004, 1'b0, "pc0");
    fetch(26'd2, 32'hFC000000, 1'b0, "pc2");

    // Overflow past the end of memory; fim arrives alone.
    inicia(3'd6);
    palavra(32'h11, 1'b0); check("pronta_w1", 64'(carga_pronta), 64'd1);
    palavra(32'h22, 1'b0); check("pronta_w2", 64'(carga_pronta), 64'd1);
    palavra(32'h33, 1'b0); check("pronta_w3", 64'(carga_pronta), 64'd1);
    palavra(32'h44, 1'b0); check("pronta_w4", 64'(carga_pronta), 64'd1);
    check("estouro_cedo", 64'(carga_estouro), 64'd1);
    carga_fim = 1'b1; prox(); carga_fim = 1'b0;
    check("estouro", 64'(carga_estouro), 64'd1);
    check("pal_2", 64'(palavras_carregadas), 64'd2);
    fetch(26'd6, 32'h11, 1'b0, "pc6");
    fetch(26'd7, 32'h22, 1'b0, "pc7");
    fetch(26'd5, 32'h0, 1'b0, "pc5");

    // Out-of-range fetches.
    fetch(26'd8, 32'h0, 1'b1, "pc8");
    fetch(26'h3FFFFFF, 32'h0, 1'b1, "pcmax");
    fetch(26'd7, 32'h22, 1'b0, "pc7b");

    // Restart mid-load; data in the restart cycle is ignored.
    inicia(3'd0);
    palavra(32'hAA, 1'b0);
    palavra(32'hBB, 1'b0);
    carga_inicio = 1'b1; carga_base = 3'd4; carga_valida = 1'b1; carga_dado = 32'hCC;
    prox();
    carga_inicio = 1'b0; carga_valida = 1'b0;
    check("restart_pal", 64'(palavras_carregadas), 64'd0);
    check("restart_est", 64'(carga_estouro), 64'd0);
    palavra(32'hDD, 1'b0);
    carga_fim = 1'b1; prox(); carga_fim = 1'b0;
    check("restart_pal1", 64'(palavras_carregadas), 64'd1);
    check("restart_est1", 64'(carga_estouro), 64'd0);
    fetch(26'd4, 32'hDD, 1'b0, "pc4");
    fetch(26'd0, 32'hAA, 1'b0, "pc0b");
    fetch(26'd1, 32'hBB, 1'b0, "pc1b");
    fetch(26'd5, 32'h0, 1'b0, "pc5b");

    // Asynchronous reset in the middle of a load.
    inicia(3'd0);
    palavra(32'h99, 1'b0);
    carga_valida = 1'b1; carga_dado = 32'h77;
    #2 reset = 1'b0;
    #1 check_reset_vals("reset_async");
    carga_valida = 1'b0;
    prox();
    reset = 1'b1;
    for (int i = 0; i < MS; i++) prox();
    for (int i = 0; i < MS; i++) fetch(PW'(i), 32'h0, 1'b0, "pos_reset");

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
